tlc_multi: RTL and testbench



---
 rtl/tlc_multi.sv | 84 ++++++++
 tb/tb_tlc_multi.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tlc_multi.sv
// tlc_multi: N-approach traffic light controller with round-robin service and latched requests
module tlc_multi #(
  parameter int N         = 4,
  parameter int IDX_W     = 2,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     sen,
  output logic [N-1:0]     red,
  output logic [N-1:0]     yellow,
  output logic [N-1:0]     green,
  output logic [IDX_W-1:0] active,
  output logic [1:0]       phase
);

  typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, ALLRED = 2'd2} state_t;

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [N-1:0]     req_q;
  logic [N-1:0]     oh;
  logic [N-1:0]     nxt_oh;
  logic [IDX_W-1:0] nxt;
  logic [IDX_W-1:0] idx;
  logic             others;
  logic             go_yellow;
  logic             go_allred;
  logic             go_green;
  logic             green_sat;

  assign oh        = N'(1) << active;
  assign nxt_oh    = N'(1) << nxt;
  assign others    = |(req_q & ~oh);
  assign green_sat = timer == CNT_W'(GREEN_MAX - 1);
  assign go_yellow = state == GREEN && timer >= CNT_W'(GREEN_MIN - 1) && others && (!sen[active] || green_sat);
  assign go_allred = state == YELLOW && timer == CNT_W'(YELLOW_T - 1);
  assign go_green  = state == ALLRED && timer == CNT_W'(ALLRED_T - 1);

  assign green  = state == GREEN  ? oh : '0;
  assign yellow = state == YELLOW ? oh : '0;
  assign red    = state == ALLRED ? '1 : ~oh;
  assign phase  = state;

  // next approach: nearest pending request after active, scanning downward so the closest wins
  always_comb begin
    nxt = active;
    idx = '0;
    for (int k = N - 1; k >= 1; k--) begin
      idx = IDX_W'((int'(active) + k) % N);
      if (req_q[idx]) nxt = idx;
    end
  end

  // phase sequencing, timer and request latching
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= GREEN;
      active <= '0;
      timer  <= '0;
      req_q  <= '0;
    end else begin
      req_q <= (req_q | (sen & ~(state == GREEN ? oh : '0))) & ~(go_green ? nxt_oh : '0);
      if (go_yellow) begin
        state <= YELLOW;
        timer <= '0;
      end else if (go_allred) begin
        state <= ALLRED;
        timer <= '0;
      end else if (go_green) begin
        state  <= GREEN;
        active <= nxt;
        timer  <= '0;
      end else if (!(state == GREEN && green_sat)) begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tlc_multi.sv
// tb_tlc_multi: directed checks of the 4-approach traffic light controller
module tb_tlc_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sen = 4'b0;
  logic [3:0] red, yellow, green;
  logic [1:0] active, phase;
  int         checks = 0;
  int         errors = 0;

  wire [15:0] obs = {green, yellow, red, active, phase};

  tlc_multi dut (
    .clk(clk), .reset(reset), .sen(sen), .red(red), .yellow(yellow),
    .green(green), .active(active), .phase(phase)
  );

  always #10 clk = ~clk;

  // expected {green,yellow,red,active,phase} for a phase and approach
  function automatic logic [15:0] expv(input int ph, input int a);
    logic [3:0] o;
    o = 4'b0001 << a;
    return {ph == 0 ? o : 4'b0, ph == 1 ? o : 4'b0, ph == 2 ? 4'hf : ~o, 2'(a), 2'(ph)};
  endfunction

  // exactly one lamp lit per approach whenever out of reset
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      assert ((green | yellow | red) === 4'hf && (green & yellow) === 4'h0 &&
              (green & red) === 4'h0 && (yellow & red) === 4'h0)
      else begin
        errors++;
        $display("FAIL one_lamp got g=%b y=%b r=%b want one lamp per approach", green, yellow, red);
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    #5;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sen = 4'b0;
    #3;
    checks++;
    if (obs !== expv(0, 0)) begin
      errors++;
      $display("FAIL reset_state got %h want %h", obs, expv(0, 0));
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (obs !== expv(0, 0)) begin
        errors++;
        $display("FAIL idle cyc %0d got %h want %h", c, obs, expv(0, 0));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_request();
    int ph[4] = '{0, 1, 2, 0};
    int ac[4] = '{0, 0, 0, 2};
    int ln[4] = '{4, 2, 1, 3};
    int cyc = 0;
    apply_reset();
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < ln[s]; k++) begin
        sen = cyc == 0 ? 4'b0100 : 4'b0000;
        checks++;
        if (obs !== expv(ph[s], ac[s])) begin
          errors++;
          $display("FAIL single_request cyc %0d got %h want %h", cyc, obs, expv(ph[s], ac[s]));
        end
        @(posedge clk); #1;
        cyc++;
      end
    checks++;
    if (dut.req_q[2] !== 1'b0) begin
      errors++;
      $display("FAIL single_request_clear got %b want 0", dut.req_q[2]);
    end
  endtask

  task automatic test_max_out();
    int ph[4] = '{0, 1, 2, 0};
    int ac[4] = '{0, 0, 0, 1};
    int ln[4] = '{12, 2, 1, 2};
    int cyc = 0;
    apply_reset();
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < ln[s]; k++) begin
        sen = cyc == 1 ? 4'b0011 : 4'b0001;
        checks++;
        if (obs !== expv(ph[s], ac[s])) begin
          errors++;
          $display("FAIL max_out cyc %0d got %h want %h", cyc, obs, expv(ph[s], ac[s]));
        end
        @(posedge clk); #1;
        cyc++;
      end
    sen = 4'b0;
  endtask

  task automatic test_round_robin();
    int ph[10] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
    int ac[10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3};
    int ln[10] = '{4, 2, 1, 4, 2, 1, 4, 2, 1, 20};
    int cyc = 0;
    apply_reset();
    for (int s = 0; s < 10; s++)
      for (int k = 0; k < ln[s]; k++) begin
        sen = cyc == 0 ? 4'b1110 : 4'b0000;
        checks++;
        if (obs !== expv(ph[s], ac[s])) begin
          errors++;
          $display("FAIL round_robin cyc %0d got %h want %h", cyc, obs, expv(ph[s], ac[s]));
        end
        @(posedge clk); #1;
        cyc++;
      end
  endtask

  task automatic test_wrap();
    int ph[7] = '{0, 1, 2, 0, 1, 2, 0};
    int ac[7] = '{3, 3, 3, 0, 0, 0, 2};
    int ln[7] = '{2, 2, 1, 4, 2, 1, 6};
    int cyc = 0;
    for (int s = 0; s < 7; s++)
      for (int k = 0; k < ln[s]; k++) begin
        sen = cyc == 0 ? 4'b0101 : 4'b0000;
        checks++;
        if (obs !== expv(ph[s], ac[s])) begin
          errors++;
          $display("FAIL wrap cyc %0d got %h want %h", cyc, obs, expv(ph[s], ac[s]));
        end
        @(posedge clk); #1;
        cyc++;
      end
  endtask

  task automatic test_reset_mid_phase();
    int ph[4] = '{0, 1, 2, 0};
    int ac[4] = '{0, 0, 0, 2};
    int ln[4] = '{4, 2, 1, 4};
    int cyc = 0;
    apply_reset();
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < ln[s]; k++) begin
        sen = cyc == 0 ? 4'b0100 : cyc == 7 ? 4'b1001 : 4'b0000;
        checks++;
        if (obs !== expv(ph[s], ac[s])) begin
          errors++;
          $display("FAIL mid_setup cyc %0d got %h want %h", cyc, obs, expv(ph[s], ac[s]));
        end
        @(posedge clk); #1;
        cyc++;
      end
    checks++;
    if (obs !== expv(1, 2)) begin
      errors++;
      $display("FAIL mid_yellow got %h want %h", obs, expv(1, 2));
    end
    reset = 1'b0;
    #5;
    checks++;
    if (obs !== expv(0, 0)) begin
      errors++;
      $display("FAIL mid_reset_out got %h want %h", obs, expv(0, 0));
    end
    checks++;
    if (dut.req_q !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_req got %b want 0000", dut.req_q);
    end
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (obs !== expv(0, 0)) begin
        errors++;
        $display("FAIL mid_resume cyc %0d got %h want %h", c, obs, expv(0, 0));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_max_out();
    test_round_robin();
    test_wrap();
    test_reset_mid_phase();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
